// File: rtl/dac_spi_tx_if.sv
// Sample handshake and serial DAC pins for dac_spi_tx.
// master = sample producer, slave = transmitter.
interface dac_spi_tx_if;
    logic [15:0] IN_A;
    logic [15:0] IN_B;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        SCLK;
    logic        SYNC_n;
    logic        DIN;
    logic        LDAC_n;

    modport master (
        output IN_A, IN_B, in_valid,
        input  in_ready, busy, done, SCLK, SYNC_n, DIN, LDAC_n
    );

    modport slave (
        input  IN_A, IN_B, in_valid,
        output in_ready, busy, done, SCLK, SYNC_n, DIN, LDAC_n
    );
endinterface

// File: rtl/dac_spi_tx.sv
// Dual-channel SPI DAC transmitter: two 24-bit write frames, then an LDAC_n pulse.
// Define DAC_OFFSET_BINARY_EN to send samples as offset binary (MSB inverted).
module dac_spi_tx #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    dac_spi_tx_if.slave  bus
);

    localparam int            CW        = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] DONE_AT   = CW'(2 * CLK_DIV - 2);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FRAME_A = 3'd1,
        ST_GAP_A   = 3'd2,
        ST_FRAME_B = 3'd3,
        ST_GAP_B   = 3'd4,
        ST_LOAD    = 3'd5
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [4:0]    bit_cnt_r;
    logic [23:0]   shift_r;
    logic [15:0]   code_b_r;
    logic          in_ready_r;
    logic          busy_r;
    logic          done_r;
    logic          sclk_r;
    logic          sync_n_r;
    logic          din_r;
    logic          ldac_n_r;
    logic [23:0]   frame_a_s;
    logic [23:0]   frame_b_s;

    function automatic logic [15:0] dac_code(input logic [15:0] sample);
`ifdef DAC_OFFSET_BINARY_EN
        return {~sample[15], sample[14:0]};
`else
        return sample;
`endif
    endfunction

    // Header: 2'b00, command 3'b000 (write input register), 3-bit address, 16-bit code
    function automatic logic [23:0] make_frame(input logic [2:0] addr, input logic [15:0] code);
        return {2'b00, 3'b000, addr, code};
    endfunction

    assign frame_a_s = make_frame(3'b000, dac_code(bus.IN_A));
    assign frame_b_s = make_frame(3'b001, code_b_r);

    assign bus.in_ready = in_ready_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.SCLK     = sclk_r;
    assign bus.SYNC_n   = sync_n_r;
    assign bus.DIN      = din_r;
    assign bus.LDAC_n   = ldac_n_r;

    // Transfer sequencer; every serial output is registered and set one cycle ahead
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            bit_cnt_r  <= 5'd0;
            shift_r    <= 24'h000000;
            code_b_r   <= 16'h0000;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            sclk_r     <= 1'b1;
            sync_n_r   <= 1'b1;
            din_r      <= 1'b0;
            ldac_n_r   <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.in_valid && in_ready_r) begin
                        shift_r    <= frame_a_s;
                        din_r      <= frame_a_s[23];
                        code_b_r   <= dac_code(bus.IN_B);
                        sync_n_r   <= 1'b0;
                        sclk_r     <= 1'b1;
                        cnt_r      <= CNT_ZERO;
                        bit_cnt_r  <= 5'd23;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_FRAME_A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FRAME_A, ST_FRAME_B: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r  <= CNT_ZERO;
                        sclk_r <= 1'b1;
                        if (bit_cnt_r == 5'd0) begin
                            sync_n_r <= 1'b1;
                            din_r    <= 1'b0;
                            state_r  <= (state_r == ST_FRAME_A) ? ST_GAP_A : ST_GAP_B;
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 5'd1;
                            shift_r   <= {shift_r[22:0], 1'b0};
                            din_r     <= shift_r[22];
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                        // falling SCLK halfway through the bit; DAC samples here
                        if (cnt_r == HALF_LAST) begin
                            sclk_r <= 1'b0;
                        end else begin
                            sclk_r <= sclk_r;
                        end
                    end
                end
                ST_GAP_A: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r     <= CNT_ZERO;
                        shift_r   <= frame_b_s;
                        din_r     <= frame_b_s[23];
                        sync_n_r  <= 1'b0;
                        bit_cnt_r <= 5'd23;
                        state_r   <= ST_FRAME_B;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_GAP_B: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r    <= CNT_ZERO;
                        ldac_n_r <= 1'b0;
                        state_r  <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    if (cnt_r == BIT_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        ldac_n_r   <= 1'b1;
                        done_r     <= 1'b0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        cnt_r  <= cnt_r + CNT_ONE;
                        done_r <= (cnt_r == DONE_AT);
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= CNT_ZERO;
                    in_ready_r <= 1'b1;
                    busy_r     <= 1'b0;
                    done_r     <= 1'b0;
                    sclk_r     <= 1'b1;
                    sync_n_r   <= 1'b1;
                    din_r      <= 1'b0;
                    ldac_n_r   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Randomized self-checking bench for dac_spi_tx at CLK_DIV=4 and CLK_DIV=1,
// checked against a frame-level model of the DAC protocol.
module tb_dac_spi_tx;

    logic clk;
    logic rst4;
    logic rst1;
    int   n_tests = 0;
    int   n_fail  = 0;

    dac_spi_tx_if if4 ();
    dac_spi_tx_if if1 ();

    dac_spi_tx #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst(rst4), .bus(if4.slave));
    dac_spi_tx #(.CLK_DIV(1)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic sclk_w [2];
    logic sync_w [2];
    logic din_w  [2];
    logic ldac_w [2];
    logic done_w [2];
    logic rdy_w  [2];
    logic busy_w [2];
    assign sclk_w[0] = if4.SCLK;     assign sclk_w[1] = if1.SCLK;
    assign sync_w[0] = if4.SYNC_n;   assign sync_w[1] = if1.SYNC_n;
    assign din_w[0]  = if4.DIN;      assign din_w[1]  = if1.DIN;
    assign ldac_w[0] = if4.LDAC_n;   assign ldac_w[1] = if1.LDAC_n;
    assign done_w[0] = if4.done;     assign done_w[1] = if1.done;
    assign rdy_w[0]  = if4.in_ready; assign rdy_w[1]  = if1.in_ready;
    assign busy_w[0] = if4.busy;     assign busy_w[1] = if1.busy;

    // Bus observer: frames as the DAC would latch them, LDAC pulse widths, done pulses
    logic [23:0] frames_q [$];
    int          ldac_q [$];
    logic [23:0] sh_m [2]      = '{24'h0, 24'h0};
    int          bits_m [2]    = '{0, 0};
    int          ldac_len [2]  = '{0, 0};
    int          done_cnt [2]  = '{0, 0};
    int          inv_err [2]   = '{0, 0};
    logic        prev_sclk [2] = '{1'b1, 1'b1};
    logic        prev_ldac [2] = '{1'b1, 1'b1};
    logic        prev_done [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if ((sync_w[i] && !sclk_w[i]) || (busy_w[i] == rdy_w[i]) ||
                (done_w[i] && ldac_w[i]) || (ldac_w[i] && !prev_ldac[i] && !prev_done[i]))
                inv_err[i] <= inv_err[i] + 1;
            if (sync_w[i]) begin
                bits_m[i] <= 0;
            end else if (prev_sclk[i] && !sclk_w[i]) begin
                sh_m[i] <= {sh_m[i][22:0], din_w[i]};
                if (bits_m[i] == 23) begin
                    frames_q.push_back({sh_m[i][22:0], din_w[i]});
                    bits_m[i] <= 0;
                end else begin
                    bits_m[i] <= bits_m[i] + 1;
                end
            end
            if (!ldac_w[i]) begin
                ldac_len[i] <= ldac_len[i] + 1;
            end else if (!prev_ldac[i]) begin
                ldac_q.push_back(ldac_len[i]);
                ldac_len[i] <= 0;
            end
            if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
            prev_sclk[i] <= sclk_w[i];
            prev_ldac[i] <= ldac_w[i];
            prev_done[i] <= done_w[i];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: what the DAC must receive for a sample on a given channel
    function automatic logic [23:0] exp_frame(input int ch, input logic [15:0] s);
        logic [15:0] code;
        code = s;
`ifdef DAC_OFFSET_BINARY_EN
        code = s + 16'h8000;
`endif
        return (24'(ch) << 16) | 24'(code);
    endfunction

    task automatic set_in(input int d, input logic [15:0] a, input logic [15:0] b, input logic v);
        if (d == 0) begin
            if4.IN_A = a; if4.IN_B = b; if4.in_valid = v;
        end else begin
            if1.IN_A = a; if1.IN_B = b; if1.in_valid = v;
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check_eq({tag, "_in_ready"}, 32'(rdy_w[d]), 32'd1);
        check_eq({tag, "_busy"},     32'(busy_w[d]), 32'd0);
        check_eq({tag, "_done"},     32'(done_w[d]), 32'd0);
        check_eq({tag, "_sclk"},     32'(sclk_w[d]), 32'd1);
        check_eq({tag, "_sync_n"},   32'(sync_w[d]), 32'd1);
        check_eq({tag, "_din"},      32'(din_w[d]),  32'd0);
        check_eq({tag, "_ldac_n"},   32'(ldac_w[d]), 32'd1);
    endtask

    task automatic wait_ready(input int d, output int lat);
        lat = 0;
        while (!rdy_w[d] && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        #1;
    endtask

    task automatic run_one(input int d, input logic [15:0] a, input logic [15:0] b);
        int div, lat, nf0, nl0, dn0;
        logic [23:0] fa;
        div = (d == 0) ? 4 : 1;
        fa  = exp_frame(0, a);
        nf0 = frames_q.size(); nl0 = ldac_q.size(); dn0 = done_cnt[d];
        @(negedge clk);
        check_eq("ready_before", 32'(rdy_w[d]), 32'd1);
        set_in(d, a, b, 1'b1);
        @(negedge clk);
        // valid stays up with junk data for one busy cycle: must be ignored
        set_in(d, 16'($urandom), 16'($urandom), 1'b1);
        check_eq("first_sync_n", 32'(sync_w[d]), 32'd0);
        check_eq("first_din",    32'(din_w[d]),  32'(fa[23]));
        check_eq("first_sclk",   32'(sclk_w[d]), 32'd1);
        check_eq("first_busy",   32'(busy_w[d]), 32'd1);
        @(negedge clk);
        set_in(d, 16'h0000, 16'h0000, 1'b0);
        wait_ready(d, lat);
        check_eq("latency", 32'(lat + 1), 32'(102 * div));
        check_eq("n_frames", 32'(frames_q.size() - nf0), 32'd2);
        if (frames_q.size() - nf0 == 2) begin
            check_eq("frame_a", 32'(frames_q[nf0]),     32'(fa));
            check_eq("frame_b", 32'(frames_q[nf0 + 1]), 32'(exp_frame(1, b)));
        end
        check_eq("n_ldac", 32'(ldac_q.size() - nl0), 32'd1);
        if (ldac_q.size() - nl0 == 1) check_eq("ldac_width", 32'(ldac_q[nl0]), 32'(2 * div));
        check_eq("n_done", 32'(done_cnt[d] - dn0), 32'd1);
    endtask

    localparam int P4 = 102 * 4 + 1;

    initial begin
        logic [15:0] ea [4];
        logic [15:0] eb [4];
        logic [15:0] a, b;
        int nf0, nl0, dn0, lat;

        rst4 = 1'b0; rst1 = 1'b0;
        set_in(0, 16'h0000, 16'h0000, 1'b0);
        set_in(1, 16'h0000, 16'h0000, 1'b0);
        repeat (3) @(negedge clk);
        check_idle(0, "in_reset");
        rst4 = 1'b1; rst1 = 1'b1;
        repeat (20) @(negedge clk);
        check_idle(0, "idle4");
        check_idle(1, "idle1");

        run_one(0, 16'h1234, 16'hABCD);
        run_one(0, 16'h0000, 16'h8000);
        run_one(0, 16'h7FFF, 16'hFFFF);
        repeat (2) run_one(0, 16'($urandom), 16'($urandom));

        // Back-to-back: in_valid held high, data changing every cycle
        nf0 = frames_q.size(); nl0 = ldac_q.size(); dn0 = done_cnt[0];
        @(negedge clk);
        for (int k = 0; k <= 3 * P4; k++) begin
            a = 16'($urandom); b = 16'($urandom);
            set_in(0, a, b, 1'b1);
            if (k % P4 == 0) begin
                check_eq("b2b_ready", 32'(rdy_w[0]), 32'd1);
                ea[k / P4] = a; eb[k / P4] = b;
            end else if (k % P4 == P4 - 1) begin
                check_eq("b2b_last_busy", 32'(rdy_w[0]), 32'd0);
            end
            @(negedge clk);
        end
        set_in(0, 16'h0000, 16'h0000, 1'b0);
        wait_ready(0, lat);
        check_eq("b2b_n_frames", 32'(frames_q.size() - nf0), 32'd8);
        if (frames_q.size() - nf0 == 8) begin
            for (int j = 0; j < 4; j++) begin
                check_eq("b2b_frame_a", 32'(frames_q[nf0 + 2 * j]),     32'(exp_frame(0, ea[j])));
                check_eq("b2b_frame_b", 32'(frames_q[nf0 + 2 * j + 1]), 32'(exp_frame(1, eb[j])));
            end
        end
        check_eq("b2b_n_ldac", 32'(ldac_q.size() - nl0), 32'd4);
        check_eq("b2b_n_done", 32'(done_cnt[0] - dn0), 32'd4);

        // Reset in the middle of frame B bit 10
        a = 16'($urandom); b = 16'($urandom);
        nf0 = frames_q.size(); nl0 = ldac_q.size(); dn0 = done_cnt[0];
        @(negedge clk);
        set_in(0, a, b, 1'b1);
        @(negedge clk);
        set_in(0, 16'h0000, 16'h0000, 1'b0);
        repeat (76 * 4 + 1) @(negedge clk);
        check_eq("pre_rst_sync_n", 32'(sync_w[0]), 32'd0);
        #2 rst4 = 1'b0;
        #1 check_idle(0, "mid_rst");
        @(negedge clk);
        @(negedge clk);
        rst4 = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_n_frames", 32'(frames_q.size() - nf0), 32'd1);
        if (frames_q.size() - nf0 == 1) check_eq("rst_frame_a", 32'(frames_q[nf0]), 32'(exp_frame(0, a)));
        check_eq("rst_no_ldac", 32'(ldac_q.size() - nl0), 32'd0);
        check_eq("rst_no_done", 32'(done_cnt[0] - dn0), 32'd0);
        run_one(0, 16'($urandom), 16'($urandom));

        // CLK_DIV = 1 instance
        run_one(1, 16'h1234, 16'hABCD);
        repeat (2) run_one(1, 16'($urandom), 16'($urandom));

        check_eq("protocol_rules4", 32'(inv_err[0]), 32'd0);
        check_eq("protocol_rules1", 32'(inv_err[1]), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
# dac_spi_tx

Dual-channel serial DAC transmitter forming the output end of the lock-in signal chain: it takes a pair of 16-bit samples (channel A, channel B) through a valid/ready handshake and shifts them out as two 24-bit SPI write frames, then pulses LDAC_n so both DAC outputs update together. It is the output-side counterpart of the parallel ADC capture stage and runs in the same system clock domain.

## Interface
- CLK_DIV, 4: SCLK half-period in clk cycles, integer >= 1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- IN_A  input  16  channel A sample, two's complement; sampled on accept.
- IN_B  input  16  channel B sample, two's complement; sampled on accept.
- in_valid  input  1  sample pair available.
- in_ready  output  1  block idle and able to accept.
- busy  output  1  transfer in progress (inverse of in_ready).
- done  output  1  one-cycle pulse at end of LDAC pulse.
- SCLK  output  1  serial clock, idles high.
- SYNC_n  output  1  frame select, active low.
- DIN  output  1  serial data, MSB first.
- LDAC_n  output  1  DAC load strobe, active low.

## Operation
- Reset values: in_ready=1, busy=0, done=0, SCLK=1, SYNC_n=1, DIN=0, LDAC_n=1; shift register and counters cleared.
- Accept: edge with in_valid=1 and in_ready=1 latches IN_A/IN_B; in_ready drops on the following cycle. in_valid while busy is ignored (no queueing).
- Frame format (24 bits, MSB first): [23:22]=2'b00, [21:19]=3'b000 (write input register), [18:16]=address (A=3'b000, B=3'b001), [15:0]=DAC code.
- FSM: IDLE -> FRAME_A -> GAP_A -> FRAME_B -> GAP_B -> LOAD -> IDLE.
- FRAME_x: SYNC_n=0; each bit lasts 2*CLK_DIV cycles: first CLK_DIV cycles SCLK=1 with DIN set to current bit, next CLK_DIV cycles SCLK=0 (DAC samples on the falling edge). 24 bits, bit counter 23 down to 0.
- GAP_x: SYNC_n=1, SCLK=1, DIN=0, 2*CLK_DIV cycles.
- LOAD: LDAC_n=0 for 2*CLK_DIV cycles; done=1 on the last LOAD cycle; next cycle IDLE with in_ready=1.
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); partial frame is abandoned, no LDAC pulse, no done.
- Accept in the same cycle that IDLE is re-entered is allowed (back-to-back transfers, zero idle cycles).

## Timing
- First DIN bit (bit 23) and SYNC_n falling edge appear on the cycle after the accept edge.
- Frame duration 48*CLK_DIV cycles; total accept-to-in_ready = 102*CLK_DIV cycles (408 at default).
- SCLK period 2*CLK_DIV clk cycles; DIN stable CLK_DIV cycles before and after each falling SCLK edge.
- SCLK is high whenever SYNC_n is high; SYNC_n rises only after the 24th falling edge plus CLK_DIV cycles of SCLK=1? No: SYNC_n rises on the first GAP cycle, exactly CLK_DIV cycles after the 24th falling edge.
- All serial outputs are registered (no combinational paths from inputs).

## Configuration
- DAC_OFFSET_BINARY_EN defined: DAC code = sample with MSB inverted (two's complement -> offset binary); 16'h0000 sends 16'h8000, 16'h8000 sends 16'h0000.
- Not defined: sample bits sent unchanged as the DAC code.

## Test plan
- Reset release, in_valid=0 -> in_ready=1, SCLK=1, SYNC_n=1, LDAC_n=1, DIN=0 held indefinitely.
- CLK_DIV=4, IN_A=16'h1234, IN_B=16'hABCD, macro off -> captured frames 24'h001234 then 24'h01ABCD on SCLK falling edges; one LDAC_n low pulse of 8 cycles; done pulse; in_ready back after 408 cycles.
- Macro on, IN_A=16'h0000, IN_B=16'h8000 -> frame A data 16'h8000, frame B data 16'h0000.
- in_valid held high continuously with changing data -> pairs accepted back-to-back, each pair sent intact, none dropped or duplicated, IN changes during busy ignored.
- rst pulsed low during bit 10 of frame B -> outputs to reset values same cycle, no LDAC_n pulse, no done; next accepted pair sent correctly.
- CLK_DIV=1 -> SCLK period 2 cycles, transfer completes in 102 cycles with correct frame contents.
